// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: shares one W-bit magnitude comparator among N requesters, granted round-robin.
// Latency: req is sampled in IDLE at edge t, and ack plus results are registered at edge t+2. One compare every 3 cycles.
// Backpressure: each requester holds req and its operands until ack. Build option CMP_SHARE_SIGNED_EN selects a two's-complement compare.
module cmp_share_arbiter #(
    parameter int W   = 4,
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   a_bus,
    input  logic [N*W-1:0]   b_bus,
    output logic [N-1:0]     ack,
    output logic             agreat,
    output logic             bgreat,
    output logic             aeb,
    output logic [IDW-1:0]   res_id,
    output logic             busy
);

    localparam logic [IDW:0]   LP_N    = (IDW+1)'(N);
    localparam logic [IDW-1:0] LP_LAST = IDW'(N-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_win;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_gt;
    logic             r_lt;
    logic             r_eq;
    logic [N-1:0]     r_ack;
    logic             r_agreat;
    logic             r_bgreat;
    logic             r_aeb;
    logic [IDW-1:0]   r_res_id;
    logic             r_busy;

    logic [2*N-1:0]   w_req_dbl;
    logic [N-1:0]     w_req_rot;
    logic [IDW-1:0]   w_off;
    logic [IDW:0]     w_sum;
    logic [IDW-1:0]   w_win;
    logic             w_any;
    logic [W-1:0]     w_win_a;
    logic [W-1:0]     w_win_b;
    logic             w_gt;
    logic             w_lt;
    logic             w_eq;
    logic [IDW-1:0]   w_rr_nxt;
    logic [N-1:0]     w_ack_oh;

    // Round-robin winner: rotate req so rr_ptr sits at bit 0, take the lowest set bit, rotate the offset back
    always_comb begin
        w_req_dbl = {req, req} >> r_rr_ptr;
        w_req_rot = w_req_dbl[N-1:0];
        w_any     = |req;
        w_off     = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_off = IDW'(k);
            end
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_win = (w_sum >= LP_N) ? IDW'(w_sum - LP_N) : IDW'(w_sum);
    end

    // Operand mux for the winning requester
    always_comb begin
        w_win_a = '0;
        w_win_b = '0;
        for (int k = 0; k < N; k++) begin
            if (w_win == IDW'(k)) begin
                w_win_a = a_bus[k*W +: W];
                w_win_b = b_bus[k*W +: W];
            end
        end
    end

    // Shared comparator on the latched operands, plus the next pointer and the ack one-hot
    always_comb begin
`ifdef CMP_SHARE_SIGNED_EN
        w_gt = $signed(r_a) > $signed(r_b);
        w_lt = $signed(r_a) < $signed(r_b);
`else
        w_gt = r_a > r_b;
        w_lt = r_a < r_b;
`endif
        w_eq     = (r_a == r_b);
        w_rr_nxt = (r_win == LP_LAST) ? '0 : r_win + 1'b1;
        w_ack_oh = N'(1) << r_win;
    end

    // Sequencer: IDLE grants and latches, CMP registers the compare, RESP publishes ack and results together
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_win    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
            r_ack    <= '0;
            r_agreat <= 1'b0;
            r_bgreat <= 1'b0;
            r_aeb    <= 1'b0;
            r_res_id <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a     <= w_win_a;
                        r_b     <= w_win_b;
                        r_win   <= w_win;
                        r_busy  <= 1'b1;
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    r_gt    <= w_gt;
                    r_lt    <= w_lt;
                    r_eq    <= w_eq;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    // Result outputs change only here, so they hold between acks
                    r_ack    <= w_ack_oh;
                    r_agreat <= r_gt;
                    r_bgreat <= r_lt;
                    r_aeb    <= r_eq;
                    r_res_id <= r_win;
                    r_rr_ptr <= w_rr_nxt;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack    = r_ack;
    assign agreat = r_agreat;
    assign bgreat = r_bgreat;
    assign aeb    = r_aeb;
    assign res_id = r_res_id;
    assign busy   = r_busy;

endmodule
